// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the core's data-memory port. Accepts one load/store
//   request at a time over a valid/ready handshake, waits LATENCY cycles,
//   then performs the access and presents the response until it is taken.
//   Handles RISC-V byte/halfword/word widths with sign/zero extension and
//   little-endian lane placement, and flags misaligned, out-of-range and
//   illegal-width accesses.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit storage words (power of two, >= 2)
//   LATENCY      wait states between acceptance and response (0..15)
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   req_valid    request present
//   req_ready    responder can accept (high only in IDLE)
//   req_addr     byte address
//   req_we       1 = store, 0 = load
//   req_funct3   access width, RISC-V funct3 encoding
//   req_wdata    store data, right-aligned
//   rsp_valid    response present (high only in RESP)
//   rsp_ready    requester takes the response
//   rsp_rdata    extended load result; 0 for stores and errors
//   rsp_err      access rejected
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT4  = 4'(LATENCY);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;

  // Request captured at acceptance
  logic [31:0] addrQ;
  logic        weQ;
  logic [2:0]  f3Q;
  logic [31:0] wdataQ;

  // Request as seen by the access logic on the committing edge
  logic [31:0] accAddr;
  logic        accWe;
  logic [2:0]  accF3;
  logic [31:0] accWdata;

  logic             accept;
  logic             commit;
  logic             accErr;
  logic             memWrite;
  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      rdWord;
  logic [7:0]       byteVal;
  logic [15:0]      halfVal;
  logic [31:0]      loadData;
  logic [3:0]       byteEn;
  logic [31:0]      storeData;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the accepting edge itself,
  // so the live request feeds the access logic; otherwise the captured copy.
  assign commit = (accept && (LAT4 == 4'd0)) ||
                  ((state == WAIT) && (cnt == 4'd1));

  always_comb begin
    accAddr  = addrQ;
    accWe    = weQ;
    accF3    = f3Q;
    accWdata = wdataQ;
    if (state == IDLE) begin
      accAddr  = req_addr;
      accWe    = req_we;
      accF3    = req_funct3;
      accWdata = req_wdata;
    end
  end

  assign wordIdx = accAddr[IDX_W+1:2];

  // Error decode
  always_comb begin
    accErr = 1'b0;
    case (accF3)
      3'b000:  accErr = 1'b0;
      3'b001:  accErr = accAddr[0];
      3'b010:  accErr = (accAddr[1:0] != 2'b00);
      3'b100:  accErr = accWe;
      3'b101:  accErr = accWe || accAddr[0];
      default: accErr = 1'b1;
    endcase
    if ({2'b00, accAddr[31:2]} >= 32'(DEPTH_WORDS)) begin
      accErr = 1'b1;
    end
  end

  // Load path: lane select and extension
  always_comb begin
    rdWord  = mem[wordIdx];
    byteVal = rdWord[7:0];
    case (accAddr[1:0])
      2'd0:    byteVal = rdWord[7:0];
      2'd1:    byteVal = rdWord[15:8];
      2'd2:    byteVal = rdWord[23:16];
      default: byteVal = rdWord[31:24];
    endcase
    halfVal = accAddr[1] ? rdWord[31:16] : rdWord[15:0];
    case (accF3)
      3'b000:  loadData = {{24{byteVal[7]}}, byteVal};
      3'b001:  loadData = {{16{halfVal[15]}}, halfVal};
      3'b010:  loadData = rdWord;
      3'b100:  loadData = {24'h000000, byteVal};
      3'b101:  loadData = {16'h0000, halfVal};
      default: loadData = '0;
    endcase
  end

  // Store path: replicate right-aligned data across lanes, enable by width
  always_comb begin
    byteEn    = 4'b0000;
    storeData = accWdata;
    case (accF3)
      3'b000: begin
        byteEn    = 4'b0001 << accAddr[1:0];
        storeData = {4{accWdata[7:0]}};
      end
      3'b001: begin
        byteEn    = accAddr[1] ? 4'b1100 : 4'b0011;
        storeData = {2{accWdata[15:0]}};
      end
      3'b010: begin
        byteEn    = 4'b1111;
        storeData = accWdata;
      end
      default: begin
        byteEn    = 4'b0000;
        storeData = accWdata;
      end
    endcase
  end

  assign memWrite = commit && accWe && !accErr;

  // Storage is deliberately not reset; contents persist across reset.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteEn[i]) begin
          mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addrQ     <= '0;
      weQ       <= 1'b0;
      f3Q       <= '0;
      wdataQ    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addrQ  <= req_addr;
            weQ    <= req_we;
            f3Q    <= req_funct3;
            wdataQ <= req_wdata;
            cnt    <= LAT4;
            state  <= (LAT4 == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (commit) begin
        rsp_rdata <= (accWe || accErr) ? '0 : loadData;
        rsp_err   <= accErr;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // sel = 0 drives the LATENCY=2 instance, sel = 1 the LATENCY=0 instance
  logic        sel;
  logic        reqValid;
  logic        rspReady;
  logic [31:0] reqAddr;
  logic        reqWe;
  logic [2:0]  reqF3;
  logic [31:0] reqWdata;

  logic        rdyA, vldA, errA;
  logic [31:0] rdA;
  logic        rdyB, vldB, errB;
  logic [31:0] rdB;

  logic        curReady, curValid, curErr;
  logic [31:0] curRdata;

  assign curReady = sel ? rdyB : rdyA;
  assign curValid = sel ? vldB : vldA;
  assign curErr   = sel ? errB : errA;
  assign curRdata = sel ? rdB  : rdA;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dutA (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (reqValid & ~sel),
    .req_ready  (rdyA),
    .req_addr   (reqAddr),
    .req_we     (reqWe),
    .req_funct3 (reqF3),
    .req_wdata  (reqWdata),
    .rsp_valid  (vldA),
    .rsp_ready  (rspReady & ~sel),
    .rsp_rdata  (rdA),
    .rsp_err    (errA)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dutB (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (reqValid & sel),
    .req_ready  (rdyB),
    .req_addr   (reqAddr),
    .req_we     (reqWe),
    .req_funct3 (reqF3),
    .req_wdata  (reqWdata),
    .rsp_valid  (vldB),
    .rsp_ready  (rspReady & sel),
    .rsp_rdata  (rdB),
    .rsp_err    (errB)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expD;
    logic        expE;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  vec_t tblA[$];
  vec_t tblB[$];
  exp_t sbq[$];

  int nChecks = 0;
  int nPass   = 0;

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] expD, input logic expE);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.expD = expD; v.expE = expE;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // One full transaction on the selected instance; entered and left at a negedge.
  task automatic doTxn(input vec_t v, input int unsigned hold, input string name);
    exp_t        e;
    exp_t        got;
    int unsigned cyc;
    int unsigned lat;
    lat = sel ? 0 : 2;
    e.rdata = v.expD;
    e.err   = v.expE;
    e.name  = name;
    sbq.push_back(e);
    reqAddr  = v.addr;
    reqWe    = v.we;
    reqF3    = v.f3;
    reqWdata = v.wdata;
    reqValid = 1'b1;
    rspReady = 1'b0;
    cyc = 0;
    while (!curReady && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkBit($sformatf("%s req_ready", name), curReady, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    cyc = 1;
    while (!curValid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s latency", name), cyc, lat + 1);
    if (sbq.size() == 0) begin
      checkBit($sformatf("%s scoreboard nonempty", name), 1'b0, 1'b1);
    end else begin
      got = sbq.pop_front();
      check($sformatf("%s rdata", got.name), curRdata, got.rdata);
      checkBit($sformatf("%s err", got.name), curErr, got.err);
      for (int unsigned i = 0; i < hold; i++) begin
        @(negedge clk);
        checkBit($sformatf("%s hold%0d valid", name, i), curValid, 1'b1);
        check($sformatf("%s hold%0d rdata", name, i), curRdata, got.rdata);
        checkBit($sformatf("%s hold%0d err", name, i), curErr, got.err);
        checkBit($sformatf("%s hold%0d req_ready", name, i), curReady, 1'b0);
      end
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkBit($sformatf("%s ready after rsp", name), curReady, 1'b1);
    checkBit($sformatf("%s valid after rsp", name), curValid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc;
    sel = 1'b0; reqValid = 1'b0; rspReady = 1'b0;
    reqAddr = '0; reqWe = 1'b0; reqF3 = '0; reqWdata = '0;

    // Reset asserted mid-cycle, outputs checked before the next edge
    #3 rst_n = 1'b0;
    #1;
    checkBit("reset A req_ready", rdyA, 1'b1);
    checkBit("reset A rsp_valid", vldA, 1'b0);
    check("reset A rsp_rdata", rdA, 32'h0);
    checkBit("reset A rsp_err", errA, 1'b0);
    checkBit("reset B req_ready", rdyB, 1'b1);
    checkBit("reset B rsp_valid", vldB, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rspReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkBit($sformatf("idle%0d rsp_valid", i), vldA, 1'b0);
      checkBit($sformatf("idle%0d req_ready", i), rdyA, 1'b1);
    end
    rspReady = 1'b0;

    // LATENCY=2 instance
    tblA.push_back(mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0));
    tblA.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0));
    tblA.push_back(mk(1, 3'b000, 32'h11,  32'h12345680, 32'h0,        0));
    tblA.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 0));
    tblA.push_back(mk(0, 3'b000, 32'h11,  32'h0,        32'hFFFFFF80, 0));
    tblA.push_back(mk(0, 3'b100, 32'h11,  32'h0,        32'h00000080, 0));
    tblA.push_back(mk(0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 0));
    tblA.push_back(mk(0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 0));
    tblA.push_back(mk(0, 3'b010, 32'h12,  32'h0,        32'h0,        1));
    tblA.push_back(mk(1, 3'b001, 32'h13,  32'h0000FFFF, 32'h0,        1));
    tblA.push_back(mk(0, 3'b010, 32'h1000, 32'h0,       32'h0,        1));
    tblA.push_back(mk(1, 3'b100, 32'h10,  32'h11111111, 32'h0,        1));
    tblA.push_back(mk(0, 3'b111, 32'h10,  32'h0,        32'h0,        1));
    tblA.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 0));
    tblA.push_back(mk(1, 3'b010, 32'h14,  32'h01234567, 32'h0,        0));
    tblA.push_back(mk(1, 3'b001, 32'h16,  32'h9999CAFE, 32'h0,        0));
    tblA.push_back(mk(0, 3'b010, 32'h14,  32'h0,        32'hCAFE4567, 0));
    tblA.push_back(mk(0, 3'b001, 32'h16,  32'h0,        32'hFFFFCAFE, 0));
    tblA.push_back(mk(0, 3'b000, 32'h14,  32'h0,        32'h00000067, 0));
    tblA.push_back(mk(0, 3'b000, 32'h17,  32'h0,        32'hFFFFFFCA, 0));
    tblA.push_back(mk(0, 3'b100, 32'h17,  32'h0,        32'h000000CA, 0));
    tblA.push_back(mk(1, 3'b000, 32'h14,  32'hFFFFFF5A, 32'h0,        0));
    tblA.push_back(mk(1, 3'b101, 32'h14,  32'h0000BEEF, 32'h0,        1));
    tblA.push_back(mk(0, 3'b011, 32'h14,  32'h0,        32'h0,        1));
    tblA.push_back(mk(0, 3'b110, 32'h14,  32'h0,        32'h0,        1));
    tblA.push_back(mk(0, 3'b010, 32'h14,  32'h0,        32'hCAFE455A, 0));
    tblA.push_back(mk(1, 3'b010, 32'hFFC, 32'h0BADF00D, 32'h0,        0));
    tblA.push_back(mk(0, 3'b010, 32'hFFC, 32'h0,        32'h0BADF00D, 0));
    tblA.push_back(mk(0, 3'b010, 32'h80000010, 32'h0,   32'h0,        1));
    tblA.push_back(mk(1, 3'b010, 32'h1000, 32'h55555555, 32'h0,       1));
    tblA.push_back(mk(1, 3'b010, 32'h20,  32'hAAAAAAAA, 32'h0,        0));
    foreach (tblA[i]) doTxn(tblA[i], 0, $sformatf("A%0d", i));

    // Backpressure: response held for 5 cycles
    doTxn(mk(0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0), 5, "backpressure lw");

    // Reset while a load response is pending
    reqAddr = 32'h10; reqWe = 1'b0; reqF3 = 3'b010; reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    cyc = 1;
    while (!vldA && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("resp-reset rdata before", rdA, 32'hDEAD80EF);
    #2 rst_n = 1'b0;
    #1;
    checkBit("resp-reset rsp_valid", vldA, 1'b0);
    check("resp-reset rsp_rdata", rdA, 32'h0);
    checkBit("resp-reset rsp_err", errA, 1'b0);
    checkBit("resp-reset req_ready", rdyA, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT drops the pending store
    reqAddr = 32'h20; reqWe = 1'b1; reqF3 = 3'b010; reqWdata = 32'h12345678;
    reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    checkBit("midstore WAIT req_ready", rdyA, 1'b0);
    checkBit("midstore WAIT rsp_valid", vldA, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkBit("midstore reset req_ready", rdyA, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    doTxn(mk(0, 3'b010, 32'h20, 32'h0, 32'hAAAAAAAA, 0), 0, "midstore lw");

    // LATENCY=0 instance, 16 words
    sel = 1'b1;
    tblB.push_back(mk(1, 3'b010, 32'h8,  32'h55AA33CC, 32'h0,        0));
    tblB.push_back(mk(0, 3'b010, 32'h8,  32'h0,        32'h55AA33CC, 0));
    tblB.push_back(mk(0, 3'b101, 32'hA,  32'h0,        32'h000055AA, 0));
    tblB.push_back(mk(0, 3'b000, 32'hB,  32'h0,        32'h00000055, 0));
    tblB.push_back(mk(0, 3'b000, 32'h9,  32'h0,        32'h00000033, 0));
    tblB.push_back(mk(0, 3'b010, 32'h40, 32'h0,        32'h0,        1));
    tblB.push_back(mk(1, 3'b010, 32'h3C, 32'h00000077, 32'h0,        0));
    tblB.push_back(mk(0, 3'b010, 32'h3C, 32'h0,        32'h00000077, 0));
    foreach (tblB[i]) doTxn(tblB[i], 0, $sformatf("B%0d", i));

    // Back-to-back sw/lw with rsp_ready tied high: one transaction per 2 cycles
    rspReady = 1'b1; reqValid = 1'b1; reqWe = 1'b1; reqF3 = 3'b010;
    reqAddr = 32'h4; reqWdata = 32'hC0FFEE00;
    @(posedge clk);
    @(negedge clk);
    checkBit("b2b sw valid", vldB, 1'b1);
    checkBit("b2b sw err", errB, 1'b0);
    check("b2b sw rdata", rdB, 32'h0);
    reqWe = 1'b0; reqWdata = '0;
    @(negedge clk);
    checkBit("b2b gap valid", vldB, 1'b0);
    checkBit("b2b gap ready", rdyB, 1'b1);
    @(negedge clk);
    checkBit("b2b lw valid", vldB, 1'b1);
    check("b2b lw rdata", rdB, 32'hC0FFEE00);
    checkBit("b2b lw err", errB, 1'b0);
    reqValid = 1'b0;
    @(negedge clk);
    checkBit("b2b end valid", vldB, 1'b0);
    rspReady = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
